// File: rtl/com_write.sv
// Reply frame builder: latches a reply descriptor, writes an 18-byte frame into TX RAM, then handshakes with the Ethernet sender.
// Optional macro COM_WRITE_SEQ_EN adds an 8-bit frame sequence number into the high byte of word 3.
module com_write #(
  parameter logic [7:0] RAM_ADDR_INIT = 8'h0A,
  parameter logic [7:0] NUM           = 8'h12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs,
  output logic        fd,
  output logic        fs_eth,
  input  logic        fd_eth,
  input  logic [15:0] device_idx,
  input  logic [3:0]  btype,
  input  logic [15:0] status,
  input  logic [11:0] com_cmd,
  input  logic [39:0] trgg_cmd,
  output logic [7:0]  txa,
  output logic [7:0]  txd,
  output logic        txen
);

  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    WAIT = 6'b000010,
    LOAD = 6'b000100,
    WORK = 6'b001000,
    SEND = 6'b010000,
    REST = 6'b100000
  } state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_num;
  logic [15:0] r_word [0:8];
  logic [7:0]  r_txa, r_txd;
  logic        r_txen;

  logic [15:0] w_word [0:7];
  logic [15:0] w_fcode;
  logic [15:0] w_word3;
  logic [15:0] w_sum;
  logic [15:0] w_cur_word;
  logic [7:0]  w_byte;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = WAIT;
      WAIT:    if (fs) w_next = LOAD;
      LOAD:    w_next = WORK;
      WORK:    if (r_num == NUM) w_next = SEND;
      SEND:    if (fd_eth) w_next = REST;
      REST:    if (!fs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign fd     = (r_state == REST);
  assign fs_eth = (r_state == SEND);

  always_comb begin
    w_fcode = 16'h0000;
    case (btype)
      4'd1:    w_fcode = 16'h001E;
      4'd2:    w_fcode = 16'h004C;
      4'd3:    w_fcode = 16'h0097;
      4'd4:    w_fcode = 16'h002D;
      4'd5:    w_fcode = 16'h00D2;
      default: w_fcode = 16'h0000;
    endcase
  end

`ifdef COM_WRITE_SEQ_EN
  logic [7:0] r_seq;
  // Counts handshakes completed with the Ethernet sender
  always_ff @(posedge clk) begin
    if (rst)                              r_seq <= 8'h00;
    else if (r_state == SEND && fd_eth)   r_seq <= r_seq + 8'h01;
  end
  assign w_word3 = {r_seq, status[7:0]};
`else
  assign w_word3 = status;
`endif

  assign w_word[0] = 16'h55AA;
  assign w_word[1] = device_idx;
  assign w_word[2] = w_fcode;
  assign w_word[3] = w_word3;
  assign w_word[4] = {4'h0, com_cmd};
  assign w_word[5] = {8'h00, trgg_cmd[39:32]};
  assign w_word[6] = trgg_cmd[31:16];
  assign w_word[7] = trgg_cmd[15:0];
  assign w_sum     = w_word[1] + w_word[2] + w_word[3] + w_word[4]
                   + w_word[5] + w_word[6] + w_word[7];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) r_word[i] <= 16'h0000;
    end else if (r_state == LOAD) begin
      for (int i = 0; i < 8; i++) r_word[i] <= w_word[i];
      r_word[8] <= w_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                  r_num <= 8'h00;
    else if (r_state == WORK) r_num <= r_num + 8'h01;
    else                      r_num <= 8'h00;
  end

  // Big-endian: even byte is the high half of the word
  assign w_cur_word = r_word[r_num[4:1]];
  assign w_byte     = r_num[0] ? w_cur_word[7:0] : w_cur_word[15:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_txa  <= RAM_ADDR_INIT;
      r_txd  <= 8'h00;
      r_txen <= 1'b0;
    end else if (r_state == WORK && r_num < NUM) begin
      r_txa  <= RAM_ADDR_INIT + r_num;
      r_txd  <= w_byte;
      r_txen <= 1'b1;
    end else begin
      r_txa  <= RAM_ADDR_INIT;
      r_txd  <= 8'h00;
      r_txen <= 1'b0;
    end
  end

  assign txa  = r_txa;
  assign txd  = r_txd;
  assign txen = r_txen;

endmodule

// File: doc/com_write.md
Name: com_write

Overview:
- Transmit-side packet builder; the counterpart of the command parser on the Ethernet path.
- On request from the control logic, it latches a reply descriptor and writes an 18-byte reply frame into the Ethernet TX RAM, one byte per cycle.
- It then hands the frame to the Ethernet sender with a level fs/fd handshake, and finally releases the requester.
- The frame layout matches the command frame: header, device index, function code, status, payload words, 16-bit additive checksum.

Parameters:
- RAM_ADDR_INIT, 8'h0A, TX RAM address of frame byte 0; byte k is written at RAM_ADDR_INIT+k.
- NUM, 8'h12, frame length in bytes (18).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- fs  in  1  build request from control, held high until fd
- fd  out  1  done to control
- fs_eth  out  1  frame-ready to Ethernet sender
- fd_eth  in  1  Ethernet sender done
- device_idx  in  16  device index for word 1
- btype  in  4  reply type: 1 CONF, 2 READ, 3 STOP, 4 RXD0, 5 RXD1
- status  in  16  status word
- com_cmd  in  12  current ADC configuration
- trgg_cmd  in  40  current trigger/delay configuration
- txa  out  8  TX RAM write address
- txd  out  8  TX RAM write data
- txen  out  1  TX RAM write enable

Behaviour:
- **Interface:** one clock; reset is synchronous and active-high (clk, rst).
- **Reset values:** state IDLE; txa=RAM_ADDR_INIT; txd=0; txen=0; fd=0; fs_eth=0; latched words=0; num=0.
- **Reset mid-operation:** rst at any point aborts the frame and restores all reset values on the next edge.
- **States (one-hot, 6 bits):** IDLE, WAIT, LOAD, WORK, SEND, REST.
  - IDLE: always goes to WAIT next cycle.
  - WAIT: go to LOAD when fs=1.
  - LOAD: single cycle. Latches word[0..7] and computes word[8]; goes to WORK.
  - WORK: num counts 0..NUM; go to SEND when num==NUM (19 WORK cycles).
  - SEND: fs_eth=1; go to REST when fd_eth=1. If fd_eth is already high on entry, exit after 1 cycle.
  - REST: fd=1; go to IDLE when fs=0.
- **fd and fs_eth** are decoded combinationally from state.
- **Frame words (big-endian, byte 2i = word[i][15:8], byte 2i+1 = word[i][7:0]):**
  - word0 = 16'h55AA
  - word1 = device_idx
  - word2 = function code by btype: 1→001E, 2→004C, 3→0097, 4→002D, 5→00D2, any other→0000
  - word3 = status
  - word4 = {4'h0, com_cmd}
  - word5 = {8'h00, trgg_cmd[39:32]}
  - word6 = trgg_cmd[31:16]
  - word7 = trgg_cmd[15:0]
  - word8 = word1+…+word7, truncated to 16 bits (wraps modulo 2^16, no carry out)
- **RAM writes (txa/txd/txen registered):**
  - In WORK with num<NUM: txa<=RAM_ADDR_INIT+num, txd<=byte[num], txen<=1.
  - Otherwise: txen<=0, txa<=RAM_ADDR_INIT, txd<=0.
  - Result: exactly 18 consecutive txen cycles, addresses ascending.
  - txen is low in the first SEND cycle, so every byte is written before fs_eth rises.
- **Input latching:**
  - All inputs are sampled only in LOAD; later changes do not affect the frame in progress.
  - fs falling before REST is ignored; the frame still completes.
- **Back-to-back requests:** after REST→IDLE→WAIT, a still-high fs is not possible (REST waits for fs=0). A new rising fs starts the next frame; minimum spacing is 2 idle cycles.

Optional Feature:
- Macro: COM_WRITE_SEQ_EN.
- Defined:
  - An 8-bit sequence counter seq (reset 0) increments on every SEND→REST transition, wrapping FF→00.
  - word3 = {seq, status[7:0]} using seq as latched in LOAD; the checksum covers this modified word3.
- Undefined:
  - word3 = status; no counter is instantiated.

Test Plan:
- btype=1, device_idx=1234, status=0001, com_cmd=ABC, trgg_cmd=12_3456_789A, pulse fs → txa 0A..1B written with bytes 55 AA 12 34 00 1E 00 01 0A BC 00 12 34 56 78 9A CA 11; txen high 18 consecutive cycles; fs_eth rises the cycle after the last write.
- Checksum wrap: device_idx=FFFF, btype=2, status=FFFF, com_cmd=FFF, trgg_cmd=FF_FFFF_FFFF → word2=004C, checksum bytes 11 46.
- btype=7 → word2 bytes 00 00; checksum excludes it; frame is otherwise normal.
- Handshake: hold fd_eth=0 for 50 cycles → fs_eth stays high and fd stays 0. Raise fd_eth → fd=1 next cycle. Hold fs high 10 cycles → fd stays high, then returns to IDLE one cycle after fs=0.
- Assert rst during WORK at num=7 → next cycle txen=0, state IDLE, fd=0, fs_eth=0. A new fs then yields a complete, correct frame.
- With COM_WRITE_SEQ_EN: three back-to-back frames with status=00AB → byte 06 reads 00, 01, 02; byte 07 reads AB each time; checksums match.
